// File: rtl/bp_fetch_pc.sv
// -----------------------------------------------------------------------------
// bp_fetch_pc
//
// Fetch-stage PC register plus a static backward-taken / forward-not-taken
// branch predictor for the 5-stage RISC-V pipeline.
//
// Each cycle the fetched instruction is decoded combinationally:
//   - conditional branches are predicted taken when their offset is negative
//     (sign bit InstrF[31]), with target PCF + B-immediate;
//   - JAL is always predicted taken, with target PCF + J-immediate;
//   - everything else, including JALR, is predicted not-taken (PCF + 4).
// The prediction drives an external 2:1 next-PC mux whose output comes back
// in on PCNextF and is loaded into the PC.
//
// The prediction {valid, taken, target, pcplus4} is carried through D and E.
// In E it is compared with the resolved outcome. A mismatch in direction,
// or in target when taken, raises RedirectE with the correct fetch address.
//
// Optional feature (macro BP_PERF_CNT_EN):
//   defined   : BranchCount / MispredCount are live 32-bit event counters.
//   undefined : no counter registers; both outputs are tied to zero.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   StallF, StallD          hold PC register / hold D-stage record
//   FlushD, FlushE          invalidate D / E records
//   InstrF                  instruction at PCF (combinational from imem)
//   PCNextF                 next-PC mux output fed back into the PC
//   PCF                     current fetch PC
//   PredTakenF, PredTargetF next-PC mux select and taken input
//   BranchE, JumpE, TakenE, TargetE   resolved control transfer in E
//   RedirectE, RedirectPCE  mispredict flag and correct fetch address
//   BranchCount, MispredCount         performance counters
// -----------------------------------------------------------------------------
module bp_fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCNextF,
    output logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        TakenE,
    input  logic [31:0] TargetE,
    output logic        RedirectE,
    output logic [31:0] RedirectPCE,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // -------------------------------------------------------------------------
    // Fetch: PC register and static prediction
    // -------------------------------------------------------------------------
    logic [31:0] pcf_reg;
    logic [31:0] pcf_next;
    logic [31:0] pcplus4_f;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [6:0]  opcode_f;

    assign PCF       = pcf_reg;
    assign pcplus4_f = pcf_reg + 32'd4;
    assign opcode_f  = InstrF[6:0];

    // Immediates are sign-extended; bit 0 is always zero for both formats.
    assign imm_b = {{20{InstrF[31]}}, InstrF[7], InstrF[30:25], InstrF[11:8], 1'b0};
    assign imm_j = {{12{InstrF[31]}}, InstrF[19:12], InstrF[20], InstrF[30:21], 1'b0};

    always_comb begin
        PredTakenF  = 1'b0;
        PredTargetF = pcplus4_f;
        case (opcode_f)
            OP_BRANCH: begin
                // Negative offset means a backward branch (likely a loop).
                PredTakenF  = InstrF[31];
                PredTargetF = pcf_reg + imm_b;
            end
            OP_JAL: begin
                PredTakenF  = 1'b1;
                PredTargetF = pcf_reg + imm_j;
            end
            default: begin
                // JALR target depends on a register, so it is never predicted.
                PredTakenF  = 1'b0;
                PredTargetF = pcplus4_f;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Prediction records in D and E
    // -------------------------------------------------------------------------
    logic        valid_d_reg;
    logic        taken_d_reg;
    logic [31:0] target_d_reg;
    logic [31:0] pcplus4_d_reg;

    logic        valid_e_reg;
    logic        taken_e_reg;
    logic [31:0] target_e_reg;
    logic [31:0] pcplus4_e_reg;

    // Flush beats stall; an internal redirect beats everything except reset.
    always_ff @(posedge clk) begin
        if (reset || FlushD || RedirectE) begin
            valid_d_reg   <= 1'b0;
            taken_d_reg   <= 1'b0;
            target_d_reg  <= 32'd0;
            pcplus4_d_reg <= 32'd0;
        end else if (!StallD) begin
            valid_d_reg   <= 1'b1;
            taken_d_reg   <= PredTakenF;
            target_d_reg  <= PredTargetF;
            pcplus4_d_reg <= pcplus4_f;
        end
    end

    // E has no stall: it takes whatever D holds each cycle.
    always_ff @(posedge clk) begin
        if (reset || FlushE || RedirectE) begin
            valid_e_reg   <= 1'b0;
            taken_e_reg   <= 1'b0;
            target_e_reg  <= 32'd0;
            pcplus4_e_reg <= 32'd0;
        end else begin
            valid_e_reg   <= valid_d_reg;
            taken_e_reg   <= taken_d_reg;
            target_e_reg  <= target_d_reg;
            pcplus4_e_reg <= pcplus4_d_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Mispredict detection in E
    // -------------------------------------------------------------------------
    logic ctrl_e;
    logic resolved_e;
    logic dir_wrong_e;
    logic tgt_wrong_e;
    logic mispredict_e;

    assign ctrl_e       = BranchE | JumpE;
    assign resolved_e   = ctrl_e & TakenE;
    assign dir_wrong_e  = resolved_e != taken_e_reg;
    // A target mismatch only matters when the transfer is actually taken.
    assign tgt_wrong_e  = resolved_e & (TargetE != target_e_reg);
    assign mispredict_e = valid_e_reg & ctrl_e & (dir_wrong_e | tgt_wrong_e);

    always_comb begin
        RedirectE   = mispredict_e;
        RedirectPCE = 32'd0;
        if (mispredict_e) begin
            RedirectPCE = resolved_e ? TargetE : pcplus4_e_reg;
        end
    end

    // -------------------------------------------------------------------------
    // PC register: reset > redirect > stall > next-PC mux
    // -------------------------------------------------------------------------
    always_comb begin
        pcf_next = PCNextF;
        if (RedirectE) begin
            pcf_next = RedirectPCE;
        end else if (StallF) begin
            pcf_next = pcf_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_reg <= RESET_PC;
        end else begin
            pcf_reg <= pcf_next;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef BP_PERF_CNT_EN
    logic [31:0] branch_cnt_reg;
    logic [31:0] mispred_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_reg  <= 32'd0;
            mispred_cnt_reg <= 32'd0;
        end else begin
            if (valid_e_reg && ctrl_e) begin
                branch_cnt_reg <= branch_cnt_reg + 32'd1;
            end
            if (mispredict_e) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

    assign BranchCount  = branch_cnt_reg;
    assign MispredCount = mispred_cnt_reg;
`else
    assign BranchCount  = 32'd0;
    assign MispredCount = 32'd0;
`endif

endmodule

// File: tb/tb_bp_fetch_pc.sv
module tb_bp_fetch_pc;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, FlushE;
    logic [31:0] InstrF;
    logic [31:0] PCNextF;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchE, JumpE, TakenE;
    logic [31:0] TargetE;
    logic        RedirectE;
    logic [31:0] RedirectPCE;
    logic [31:0] BranchCount, MispredCount;

    int n_cmp = 0;
    int n_bad = 0;

    bp_fetch_pc #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .InstrF(InstrF), .PCNextF(PCNextF), .PCF(PCF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .BranchE(BranchE), .JumpE(JumpE), .TakenE(TakenE), .TargetE(TargetE),
        .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
        .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: NOPs except a few control transfers.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'hFE00_0CE3; // beq x0,x0,-8
            32'h0000_0300: return 32'h0400_006F; // jal x0,+0x40
            32'h0000_0400: return 32'h0000_8067; // jalr x0,0(x1)
            32'h0000_0500: return 32'h0000_1863; // bne x0,x0,+0x10
            32'h0000_0004: return 32'hFF9F_F06F; // jal x0,-8 (wraps)
            default:       return 32'h0000_0013; // nop
        endcase
    endfunction

    always_comb InstrF = imem(PCF);
    // Downstream next-PC mux.
    assign PCNextF = PredTakenF ? PredTargetF : PCF + 32'd4;

    typedef struct packed {
        logic        sf, sd, fd, fe, be, je, te;
        logic [31:0] tgt;
        logic [31:0] pcf;
        logic        ptk;
        logic [31:0] ptg;
        logic        rd;
        logic [31:0] rpc;
    } vec_t;

    function automatic vec_t mk(input logic sf, sd, fd, fe, be, je, te,
                                input logic [31:0] tgt, pcf,
                                input logic ptk, input logic [31:0] ptg,
                                input logic rd, input logic [31:0] rpc);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
        v.be = be; v.je = je; v.te = te; v.tgt = tgt;
        v.pcf = pcf; v.ptk = ptk; v.ptg = ptg; v.rd = rd; v.rpc = rpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs (just after posedge), check at negedge,
    // then advance to just after the next posedge.
    task automatic apply(input vec_t v, input string tag);
        StallF = v.sf; StallD = v.sd; FlushD = v.fd; FlushE = v.fe;
        BranchE = v.be; JumpE = v.je; TakenE = v.te; TargetE = v.tgt;
        @(negedge clk);
        chk({tag, "_pcf"},  PCF,                  v.pcf);
        chk({tag, "_ptk"},  {31'd0, PredTakenF},  {31'd0, v.ptk});
        chk({tag, "_ptg"},  PredTargetF,          v.ptg);
        chk({tag, "_rd"},   {31'd0, RedirectE},   {31'd0, v.rd});
        chk({tag, "_rpc"},  RedirectPCE,          v.rpc);
        $display("cycle %s: PCF=%08h ptk=%0b ptg=%08h redir=%0b rpc=%08h",
                 tag, PCF, PredTakenF, PredTargetF, RedirectE, RedirectPCE);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [31:0] exp_bc, exp_mc;

    initial begin
        // sf sd fd fe be je te  tgt           pcf           ptk ptg          rd rpc
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h100,      0, 32'h104,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h104,      0, 32'h108,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h108,      0, 32'h10C,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h200,      32'h10C,      0, 32'h110,      1, 32'h200));
        // backward beq: predicted taken, resolves not-taken
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h200,      1, 32'h1F8,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h1F8,      0, 32'h1FC,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 32'h1F8,      32'h1FC,      0, 32'h200,      1, 32'h204));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h204,      0, 32'h208,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h208,      0, 32'h20C,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h300,      32'h20C,      0, 32'h210,      1, 32'h300));
        // jal: predicted taken, correct
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h300,      1, 32'h340,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h340,      0, 32'h344,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h340,      32'h344,      0, 32'h348,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h400,      32'h348,      0, 32'h34C,      1, 32'h400));
        // jalr: redirect beats StallF and StallD
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h400,      0, 32'h404,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h404,      0, 32'h408,      0, 32'h0));
        vecs.push_back(mk(1,1,0,0,0,1,1, 32'h800,      32'h408,      0, 32'h40C,      1, 32'h800));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h800,      0, 32'h804,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h123,      32'h804,      0, 32'h808,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h500,      32'h808,      0, 32'h80C,      1, 32'h500));
        // forward bne flushed out of E
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h500,      0, 32'h510,      0, 32'h0));
        vecs.push_back(mk(0,0,0,1,0,0,0, 32'h0,        32'h504,      0, 32'h508,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,1,0,1, 32'h510,      32'h508,      0, 32'h50C,      0, 32'h0));
        // StallF holds; StallD+FlushD clears D
        vecs.push_back(mk(1,1,0,0,0,0,0, 32'h0,        32'h50C,      0, 32'h510,      0, 32'h0));
        vecs.push_back(mk(0,1,1,0,0,0,0, 32'h0,        32'h50C,      0, 32'h510,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h510,      0, 32'h514,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h999,      32'h514,      0, 32'h518,      0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'h4,        32'h518,      0, 32'h51C,      1, 32'h4));
        // backward jal wrapping below zero; taken with wrong target
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'h4,        1, 32'hFFFFFFFC, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'hFFFFFFFC, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,1,1, 32'hFFFFFFF8, 32'h0,        0, 32'h4,        1, 32'hFFFFFFF8));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'hFFFFFFF8, 0, 32'hFFFFFFFC, 0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        32'hFFFFFFFC, 0, 32'h0,        0, 32'h0));

        // Reset
        reset = 1'b1;
        StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
        BranchE = 0; JumpE = 0; TakenE = 0; TargetE = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_pcf", PCF, 32'h100);
        chk("reset_rd",  {31'd0, RedirectE}, 32'd0);
        chk("reset_rpc", RedirectPCE, 32'h0);
        chk("reset_bc",  BranchCount, 32'h0);
        chk("reset_mc",  MispredCount, 32'h0);
        $display("cycle reset: PCF=%08h redir=%0b", PCF, RedirectE);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Mid-operation reset while E holds a valid record that would redirect.
        reset = 1'b1;
        JumpE = 1'b1; TakenE = 1'b1; TargetE = 32'h700;
        @(negedge clk);
        chk("midrst_pre_rd", {31'd0, RedirectE}, 32'd1);
        $display("cycle midrst: PCF=%08h redir=%0b", PCF, RedirectE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_pcf", PCF, 32'h100);
        chk("midrst_rd",  {31'd0, RedirectE}, 32'd0);
        chk("midrst_rpc", RedirectPCE, 32'h0);
        chk("midrst_bc",  BranchCount, 32'h0);
        $display("cycle postrst: PCF=%08h redir=%0b", PCF, RedirectE);
        @(posedge clk);
        #1;

        // Counter sequence: 3 resolved transfers in E, the last one mispredicted.
        apply(mk(0,0,0,0,0,0,0, 32'h0,   32'h104, 0, 32'h108, 0, 32'h0),   "cnt0");
        apply(mk(0,0,0,0,1,0,0, 32'h0,   32'h108, 0, 32'h10C, 0, 32'h0),   "cnt1");
        apply(mk(0,0,0,0,1,0,0, 32'h0,   32'h10C, 0, 32'h110, 0, 32'h0),   "cnt2");
        apply(mk(0,0,0,0,0,1,1, 32'h200, 32'h110, 0, 32'h114, 1, 32'h200), "cnt3");
`ifdef BP_PERF_CNT_EN
        exp_bc = 32'd3;
        exp_mc = 32'd1;
`else
        exp_bc = 32'd0;
        exp_mc = 32'd0;
`endif
        @(negedge clk);
        chk("cnt_pcf", PCF, 32'h200);
        chk("cnt_branch",  BranchCount,  exp_bc);
        chk("cnt_mispred", MispredCount, exp_mc);
        $display("cycle counters: BranchCount=%0d MispredCount=%0d", BranchCount, MispredCount);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_fetch_pc.md
# bp_fetch_pc

Fetch-stage PC register and static branch predictor for the 5-stage pipelined RISC-V core. Each cycle it decodes the fetched instruction and applies a backward-taken/forward-not-taken (BTFN) rule. It drives the select and taken-target inputs of the downstream 32-bit next-PC 2-to-1 mux, and loads the mux result back into the PC. It carries each prediction through D and E, compares it with the resolved outcome in E, and issues the redirect on a mispredict.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PC register
- StallD  in  1  hold D-stage prediction record
- FlushD  in  1  invalidate D-stage record
- FlushE  in  1  invalidate E-stage record
- InstrF  in  32  instruction fetched at PCF (combinational from imem)
- PCNextF  in  32  next-PC mux output: PredTakenF ? PredTargetF : PCF+4
- PCF  out  32  current fetch PC
- PredTakenF  out  1  next-PC mux select
- PredTargetF  out  32  next-PC mux taken input
- BranchE  in  1  E holds a conditional branch
- JumpE  in  1  E holds JAL or JALR
- TakenE  in  1  resolved direction; ignored unless BranchE|JumpE
- TargetE  in  32  resolved target address
- RedirectE  out  1  mispredict detected in E
- RedirectPCE  out  32  correct fetch address when RedirectE=1
- BranchCount  out  32  resolved control-transfer count (see Configuration)
- MispredCount  out  32  mispredict count (see Configuration)

## Operation
- Prediction (combinational on InstrF/PCF):
  - opcode 1100011 (B-type): PredTakenF = InstrF[31]; PredTargetF = PCF + sext B-imm.
  - opcode 1101111 (JAL): PredTakenF = 1; PredTargetF = PCF + sext J-imm.
  - JALR and all other opcodes: PredTakenF = 0; PredTargetF = PCF + 4.
- All additions are 32-bit, modulo 2^32. Wrap-around is legal and not flagged.
- PC register update, in priority order:
  - reset → RESET_PC
  - RedirectE → RedirectPCE
  - StallF → hold
  - otherwise → PCNextF
- Prediction record {valid, taken, target, pcplus4}:
  - F→D: on reset, FlushD or RedirectE, D is cleared (valid=0). Otherwise, if !StallD, D loads the F record with valid=1.
  - D→E: on reset, FlushE or RedirectE, E is cleared. Otherwise, E loads D every cycle; E has no stall.
  - The clear on RedirectE is internal and applies regardless of what the hazard unit drives.
- Mispredict in E, with resolved = (BranchE|JumpE) & TakenE:
  - RedirectE = validE & (BranchE|JumpE) & ((resolved != takenE) | (resolved & TargetE != targetE)).
  - RedirectPCE = resolved ? TargetE : pcplus4E.
  - RedirectPCE = 0 when RedirectE=0.
- JALR is never predicted taken, so a taken JALR always redirects.

## Timing
- Prediction is zero-latency: PredTakenF and PredTargetF are valid in the same cycle as InstrF.
- The branch penalty is 0 cycles when the prediction is correct. When RedirectE is asserted in cycle n, PCF = RedirectPCE in cycle n+1, and the D and E records are invalid in cycle n+1. This is a 2-slot penalty.
- RedirectE overrides StallF and StallD.
- A simultaneous FlushD and !StallD clears D. A simultaneous StallD and FlushD also clears D, because flush wins over stall.
- Reset values: PCF = RESET_PC; D and E records are invalid, so RedirectE = 0 and RedirectPCE = 0; both counters are 0.
- A reset asserted mid-operation discards in-flight records on the same edge. Nothing is redirected after reset.

## Configuration
- BP_PERF_CNT_EN defined:
  - BranchCount increments on each cycle with validE & (BranchE|JumpE).
  - MispredCount increments on each cycle with RedirectE.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- BP_PERF_CNT_EN undefined: no counter registers are built, and BranchCount and MispredCount are tied to 0.

## Test plan
- Reset with RESET_PC=32'h100, then release with no stalls and NOP stream → PCF sequence 0x100, 0x104, 0x108; RedirectE stays 0.
- InstrF = beq with offset -8 at PCF=0x200 → PredTakenF=1, PredTargetF=0x1F8; next PCF=0x1F8. Two cycles later, BranchE=1, TakenE=0 → RedirectE=1, RedirectPCE=0x204; next PCF=0x204.
- InstrF = jal offset +0x40 at PCF=0x300 → PredTakenF=1, PCF=0x340 next. In E, JumpE=1, TakenE=1, TargetE=0x340 → RedirectE=0.
- JALR at 0x400 resolving TargetE=0x800 with StallF=1 in that same cycle → RedirectE=1; PCF=0x800 on the next edge (redirect beats stall).
- Forward bne (+0x10) at 0x500 predicted not-taken, FlushE asserted while the record is in D → record invalid in E; BranchE=1, TakenE=1 → RedirectE=0.
- With BP_PERF_CNT_EN: 3 resolved branches, 1 mispredicted → BranchCount=3, MispredCount=1. Without it, both read 0.
